cpu_control: RTL
================

# cpu_control

Multi-cycle sequencer for the simple CPU core. It owns the program counter and fetches 32-bit instructions over a req/ack instruction-memory handshake. It latches each instruction and enables the combinational instruction decoder for one cycle, then steps the register file and ALU through read, execute and writeback. It stops permanently on a decoded HLT. It sits in the CPU top between instruction memory, the decoder, and the regfile/ALU datapath.

## Interface
- PC_W, 16, program counter and instruction address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; permits fetching new instructions
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  fetched instruction word
- instr  out  32  latched instruction, drives the decoder's instr input
- dec_en  out  1  decoder enable
- dec_halt  in  1  decoder halt flag
- dec_opcode  in  6  decoder opcode field
- dec_imm  in  16  decoder immediate field
- rf_re  out  1  register-file read strobe
- alu_en  out  1  ALU execute strobe
- rf_we  out  1  register-file write strobe
- pc  out  PC_W  current program counter
- icount  out  16  retired-instruction count, excluding HLT
- busy  out  1  high in FETCH, DECODE, EXEC and WB
- halted  out  1  sticky halt indicator

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: if run=1, go to FETCH.
- FETCH: imem_req=1 and imem_addr=pc. Hold until imem_ack=1, then latch instr<=imem_data and go to DECODE.
- DECODE: dec_en=1 and rf_re=1. Sample dec_halt, dec_opcode and dec_imm at the end of the cycle.
  - dec_halt=1: go to HALT.
  - otherwise: go to EXEC.
- EXEC: alu_en=1, go to WB.
- WB:
  - rf_we=1 unless opcode is NOP (000000) or JMP (001100).
  - JMP: pc<=dec_imm[PC_W-1:0]. Otherwise pc<=pc+1 modulo 2^PC_W.
  - icount<=icount+1, wrapping at 0xFFFF->0.
  - Next state: FETCH if run=1, else IDLE.
- HALT: halted=1. pc is not advanced. All strobes are 0. run is ignored. Only rst leaves HALT.
- imem_ack outside FETCH is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, icount=0. imem_req, dec_en, rf_re, alu_en, rf_we, busy and halted are all 0.
- Outputs are registered state decodes.
- Strobes dec_en, rf_re, alu_en and rf_we are exactly one cycle wide.
- Instruction latency with zero-wait memory (ack in the first FETCH cycle) is 4 cycles per instruction. Each wait cycle adds 1.
- imem_req stays high, with imem_addr stable, until the ack cycle inclusive. It drops in the cycle after ack.
- run falling mid-instruction: the current instruction completes through WB, then the block goes to IDLE. There is no abort.
- rst mid-operation: all outputs return to their reset values immediately (asynchronous). Any in-flight fetch is abandoned.
- pc=2^PC_W-1 followed by a non-JMP instruction wraps pc to 0.
- A JMP to its own address loops indefinitely. This is legal.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP=6'b000000, OP_HLT=6'b001011, OP_JMP=6'b001100;
  - instruction field bit positions (pfix 31:30, opcode 29:24, rs 23:20, rd 19:16, imm 15:0);
  - the control state enum.
- The decoder is instantiated beside this block in the CPU top, not inside it.
- One sub-module: pc_counter. It is a PC_W-bit register with async reset to RESET_PC, a load port (JMP) and an increment port (wrap).

## Test plan
- Zero-wait fetch of NOP at 0x0000, then ADD (non-special opcode) at 0x0001, run=1 → 4-cycle cadence. imem_addr 0x0000 then 0x0001. rf_we=0 for NOP and 1 for ADD. icount=2.
- imem_ack delayed by 3 cycles → imem_req held 4 cycles with imem_addr stable; total instruction time 7 cycles.
- Instruction 0x0C00_0040 (JMP, imm=0x0040) at pc=0x0010 → next imem_addr=0x0040, rf_we=0 in WB.
- HLT word 0x0B00_0000 at pc=0x0005 → HALT after DECODE. halted=1, pc stays 0x0005, icount unchanged, no further imem_req while run=1.
- pc preset to 0xFFFF via JMP, then execute a NOP → next fetch address 0x0000.
- rst asserted during FETCH wait and during EXEC → same-cycle return to IDLE, pc=RESET_PC, icount=0, all strobes 0. run=0 during DECODE → instruction finishes WB, then IDLE with busy=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU core: opcodes, instruction field
// positions and the control sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int IMM_W    = 16;

  // Opcodes the sequencer treats specially.
  localparam logic [OPCODE_W-1:0] OP_NOP = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_HLT = 6'b001011;
  localparam logic [OPCODE_W-1:0] OP_JMP = 6'b001100;

  // Instruction word field positions.
  localparam int PFIX_HI = 31;
  localparam int PFIX_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 24;
  localparam int RS_HI   = 23;
  localparam int RS_LO   = 20;
  localparam int RD_HI   = 19;
  localparam int RD_LO   = 16;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  // Control sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_t;

  // NOP and JMP leave the register file untouched; everything else writes back.
  function automatic logic op_writes_rf(input logic [OPCODE_W-1:0] op);
    return !((op == OP_NOP) || (op == OP_JMP));
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: async reset to RESET_PC, jump load, wrapping increment.
module pc_counter #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Load takes priority over increment; increment wraps naturally at 2^PC_W.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control sequencer: fetch over req/ack, one-cycle decode enable,
// then register read, execute and writeback strobes; stops for good on HLT.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [INSTR_W-1:0]  instr,
  output logic                dec_en,
  input  logic                dec_halt,
  input  logic [OPCODE_W-1:0] dec_opcode,
  input  logic [IMM_W-1:0]    dec_imm,
  output logic                rf_re,
  output logic                alu_en,
  output logic                rf_we,
  output logic [PC_W-1:0]     pc,
  output logic [15:0]         icount,
  output logic                busy,
  output logic                halted
);

  ctrl_state_t         state;
  ctrl_state_t         state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic [IMM_W-1:0]    imm_q;
  logic                pc_load;
  logic                pc_inc;
  logic [PC_W-1:0]     jmp_target;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and registered-state output decodes.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dec_en   = 1'b0;
    rf_re    = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        dec_en   = 1'b1;
        rf_re    = 1'b1;
        busy     = 1'b1;
        state_nx = dec_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        alu_en   = 1'b1;
        busy     = 1'b1;
        state_nx = ST_WB;
      end
      ST_WB: begin
        rf_we    = op_writes_rf(op_q);
        busy     = 1'b1;
        pc_load  = (op_q == OP_JMP);
        pc_inc   = (op_q != OP_JMP);
        state_nx = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Latch the fetched word only in the ack cycle; stray acks elsewhere are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= '0;
    end else if ((state == ST_FETCH) && imem_ack) begin
      instr <= imem_data;
    end
  end

  // Hold the decoder's opcode and immediate for use in writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_NOP;
      imm_q <= '0;
    end else if (state == ST_DECODE) begin
      op_q  <= dec_opcode;
      imm_q <= dec_imm;
    end
  end

  // Retired-instruction counter; HLT never reaches WB so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount <= '0;
    end else if (state == ST_WB) begin
      icount <= icount + 16'd1;
    end
  end

  assign jmp_target = PC_W'(imm_q);
  assign imem_addr  = pc;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (jmp_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

endmodule
